i2s_rx: RTL and testbench

I2S_RX -- requirements
Module: i2s_rx

---
 rtl/i2s_rx_pkg.sv | 37 +++
 rtl/i2s_sync_edge.sv | 45 ++++
 rtl/i2s_rx.sv | 194 +++++++++++++++++++
 tb/tb_i2s_rx.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/i2s_rx_pkg.sv
// Shared I2S receiver definitions.
//
// Holds the I2S constants (default word width, nominal slot width, channel
// encoding) and the I2S pin bundle type used by the receiver and its
// synchronizer sub-module.
package i2s_rx_pkg;

  // Default received word width in bits.
  localparam int unsigned I2sDw = 24;

  // Nominal slot width of a 64fs stream; shorter or longer slots are also accepted.
  localparam int unsigned I2sSlotWidth = 32;

  // Word-select encoding: lrclk low carries the left channel.
  typedef enum logic {
    ChLeft  = 1'b0,
    ChRight = 1'b1
  } i2s_ch_e;

  // The three I2S pins as seen by the receiver.
  typedef struct packed {
    logic sclk;
    logic lrclk;
    logic sdi;
  } i2s_bus_t;

  // A left word starts when the channel owning the current bit switches to left.
  function automatic logic is_left_start(input i2s_ch_e cur, input i2s_ch_e prev);
    return (cur == ChLeft) && (prev == ChRight);
  endfunction

  // A right word starts when the channel owning the current bit switches to right.
  function automatic logic is_right_start(input i2s_ch_e cur, input i2s_ch_e prev);
    return (cur == ChRight) && (prev == ChLeft);
  endfunction

endpackage

// File: rtl/i2s_sync_edge.sv
// Multi-flop synchronizer with rising-edge detector.
//
// Ports:
//   clk  - module clock
//   rst  - asynchronous active-low reset, clears the chain and the edge history
//   d    - asynchronous input
//   q    - synchronized copy of d (SYNC clk cycles of latency)
//   rise - one-cycle pulse when q goes 0 -> 1
module i2s_sync_edge #(
  parameter int unsigned SYNC = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise
);

  logic [SYNC-1:0] sync_q;
  logic [SYNC-1:0] sync_d;
  logic            prev_q;

  // Shift chain: stage 0 takes the raw input, the last stage is the output.
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = d;
    for (int i = 1; i < int'(SYNC); i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= sync_q[SYNC-1];
    end
  end

  assign q    = sync_q[SYNC-1];
  assign rise = sync_q[SYNC-1] & ~prev_q;

endmodule

// File: rtl/i2s_rx.sv
// I2S slave receiver producing {left, right} sample pairs for a FIFO.
//
// Ports:
//   clk      - module clock, the only clock
//   rst      - asynchronous active-low reset
//   sclk     - I2S bit clock (asynchronous, at most clk/4)
//   lrclk    - word select, 0 = left, 1 = right
//   sdi      - serial data, MSB first, one bit after the lrclk change
//   ldata    - left sample of the last written pair
//   rdata    - right sample of the last written pair
//   wr_en    - one-cycle FIFO write strobe for {ldata, rdata}
//   full     - FIFO full; a pair completing while full is dropped
//   overflow - sticky, set when a pair was dropped, cleared by reset only
module i2s_rx
  import i2s_rx_pkg::*;
#(
  parameter int unsigned DW   = I2sDw,
  parameter int unsigned SYNC = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sclk,
  input  logic          lrclk,
  input  logic          sdi,
  output logic [DW-1:0] ldata,
  output logic [DW-1:0] rdata,
  output logic          wr_en,
  input  logic          full,
  output logic          overflow
);

  localparam int unsigned CntW = $clog2(DW + 1);

  // Synchronized pins.
  i2s_bus_t bus_s;
  logic     sclk_rise;
  logic     lrclk_rise;
  logic     sdi_rise;

  i2s_sync_edge #(
    .SYNC (SYNC)
  ) u_sync_sclk (
    .clk  (clk),
    .rst  (rst),
    .d    (sclk),
    .q    (bus_s.sclk),
    .rise (sclk_rise)
  );

  i2s_sync_edge #(
    .SYNC (SYNC)
  ) u_sync_lrclk (
    .clk  (clk),
    .rst  (rst),
    .d    (lrclk),
    .q    (bus_s.lrclk),
    .rise (lrclk_rise)
  );

  i2s_sync_edge #(
    .SYNC (SYNC)
  ) u_sync_sdi (
    .clk  (clk),
    .rst  (rst),
    .d    (sdi),
    .q    (bus_s.sdi),
    .rise (sdi_rise)
  );

  // Only the sclk edge and the lrclk/sdi levels are needed.
  logic unused_sync;
  assign unused_sync = ^{bus_s.sclk, lrclk_rise, sdi_rise};

  // ws_p: lrclk at the previous rise, i.e. the channel owning the current bit.
  // ch:   ws_p as it was at the previous rise, i.e. the channel of the previous bit.
  i2s_ch_e         ws_p_q, ws_p_d;
  i2s_ch_e         ch_q, ch_d;
  // Counts the first two rises after reset; until then ws_p/ch are reset
  // values rather than sampled ones, so no word boundary is trusted.
  logic [1:0]      prime_q, prime_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [DW-1:0]   sr_q, sr_d;
  logic [DW-1:0]   lhold_q, lhold_d;
  // locked: a start-of-left boundary has been seen since reset.
  // lvalid: lhold holds a complete left word awaiting its right partner.
  logic            locked_q, locked_d;
  logic            lvalid_q, lvalid_d;
  logic [DW-1:0]   ldata_q, ldata_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            wr_en_q, wr_en_d;
  logic            ovf_q, ovf_d;

  logic            primed;
  logic            left_start;
  logic            right_start;

  assign primed      = (prime_q == 2'd2);
  assign left_start  = primed && is_left_start(ws_p_q, ch_q);
  assign right_start = primed && is_right_start(ws_p_q, ch_q);

  always_comb begin
    ws_p_d   = ws_p_q;
    ch_d     = ch_q;
    prime_d  = prime_q;
    cnt_d    = cnt_q;
    sr_d     = sr_q;
    lhold_d  = lhold_q;
    locked_d = locked_q;
    lvalid_d = lvalid_q;
    ldata_d  = ldata_q;
    rdata_d  = rdata_q;
    wr_en_d  = 1'b0;
    ovf_d    = ovf_q;

    if (sclk_rise) begin
      ws_p_d = i2s_ch_e'(bus_s.lrclk);
      ch_d   = ws_p_q;
      if (!primed) begin
        prime_d = prime_q + 2'd1;
      end

      if (left_start || right_start) begin
        // This bit is the MSB of a new word; the LSBs start out zero so a
        // short slot ends up left-justified.
        cnt_d        = CntW'(1);
        sr_d         = '0;
        sr_d[DW-1]   = bus_s.sdi;

        if (left_start) begin
          // The right slot just finished: emit the pair if it is complete.
          locked_d = 1'b1;
          if (locked_q && lvalid_q) begin
            lvalid_d = 1'b0;
            if (full) begin
              ovf_d = 1'b1;
            end else begin
              ldata_d = lhold_q;
              rdata_d = sr_q;
              wr_en_d = 1'b1;
            end
          end
        end else if (locked_q) begin
          // The left slot just finished and started after lock, so it is whole.
          lhold_d  = sr_q;
          lvalid_d = 1'b1;
        end
      end else if (cnt_q < CntW'(DW)) begin
        // Place the bit at its MSB-first position; bits past DW are dropped.
        for (int unsigned i = 0; i < DW; i++) begin
          if (cnt_q == CntW'(DW - 1 - i)) begin
            sr_d[i] = bus_s.sdi;
          end
        end
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ws_p_q   <= ChRight;
      ch_q     <= ChRight;
      prime_q  <= '0;
      cnt_q    <= '0;
      sr_q     <= '0;
      lhold_q  <= '0;
      locked_q <= 1'b0;
      lvalid_q <= 1'b0;
      ldata_q  <= '0;
      rdata_q  <= '0;
      wr_en_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      ws_p_q   <= ws_p_d;
      ch_q     <= ch_d;
      prime_q  <= prime_d;
      cnt_q    <= cnt_d;
      sr_q     <= sr_d;
      lhold_q  <= lhold_d;
      locked_q <= locked_d;
      lvalid_q <= lvalid_d;
      ldata_q  <= ldata_d;
      rdata_q  <= rdata_d;
      wr_en_q  <= wr_en_d;
      ovf_q    <= ovf_d;
    end
  end

  assign ldata    = ldata_q;
  assign rdata    = rdata_q;
  assign wr_en    = wr_en_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_i2s_rx.sv
`timescale 1ns / 1ps
// Scoreboard bench for i2s_rx: a driver plays I2S frames and pushes the pair
// each complete frame should produce; a monitor pops on every wr_en.
module tb_i2s_rx;

  localparam int unsigned DW = 24;
  localparam int          SclkHalf = 250;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          sclk = 1'b1;
  logic          lrclk = 1'b1;
  logic          sdi = 1'b0;
  logic          full = 1'b0;
  logic [DW-1:0] ldata;
  logic [DW-1:0] rdata;
  logic          wr_en;
  logic          overflow;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
  } pair_t;

  pair_t exp_q[$];
  pair_t pend;
  bit    pend_v = 1'b0;
  bit    ovf_exp = 1'b0;
  pair_t mon_e;

  always #40 clk = ~clk;

  i2s_rx #(
    .DW   (DW),
    .SYNC (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sclk     (sclk),
    .lrclk    (lrclk),
    .sdi      (sdi),
    .ldata    (ldata),
    .rdata    (rdata),
    .wr_en    (wr_en),
    .full     (full),
    .overflow (overflow)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every write must match the oldest outstanding expected pair.
  always @(negedge clk) begin
    if (rst && wr_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual=%h_%h required=no_write", ldata, rdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("ldata", 64'(ldata), 64'(mon_e.l));
        check("rdata", 64'(rdata), 64'(mon_e.r));
      end
    end
  end

  // One bit period: data and word select change while sclk is low.
  task automatic drive_bit(input logic lr, input logic d);
    sclk  = 1'b0;
    lrclk = lr;
    sdi   = d;
    #SclkHalf;
    sclk = 1'b1;
    #SclkHalf;
  endtask

  // The next left MSB closes the pending frame: it is written unless full.
  task automatic commit();
    if (pend_v) begin
      if (full) ovf_exp = 1'b1;
      else exp_q.push_back(pend);
      pend_v = 1'b0;
    end
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst = 1'b0;
    pend_v  = 1'b0;
    ovf_exp = 1'b0;
    #1;
    check("rst_ldata", 64'(ldata), 64'(0));
    check("rst_rdata", 64'(rdata), 64'(0));
    check("rst_wr_en", 64'(wr_en), 64'(0));
    check("rst_overflow", 64'(overflow), 64'(0));
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  // Left-justified value a receiver must produce from an n-bit slot.
  function automatic logic [DW-1:0] justify(input logic [DW-1:0] w, input int slot);
    int sh;
    if (slot >= int'(DW)) return w;
    sh = int'(DW) - slot;
    return (w >> sh) << sh;
  endfunction

  // rst_at >= 0 pulses reset before that right-slot bit; pause_at >= 0 stops
  // sclk (held high) after that left-slot bit.
  task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input int slot,
                            input bit fl, input int rst_at, input int pause_at);
    full = fl;
    commit();
    for (int i = 0; i < slot; i++) begin
      drive_bit(i == slot - 1, (i < int'(DW)) ? l[int'(DW) - 1 - i] : 1'($urandom));
      if (i == pause_at) repeat (30) @(posedge clk);
    end
    full = 1'b0;
    for (int i = 0; i < slot; i++) begin
      if (i == rst_at) reset_pulse();
      drive_bit(i != slot - 1, (i < int'(DW)) ? r[int'(DW) - 1 - i] : 1'($urandom));
    end
    if (rst_at < 0) begin
      pend.l = justify(l, slot);
      pend.r = justify(r, slot);
      pend_v = 1'b1;
    end
    check("overflow", 64'(overflow), 64'(ovf_exp));
  endtask

  // Reset released while lrclk = 1, then a partial right slot ending in the
  // lrclk fall; the first full frame follows.
  task automatic start_phase();
    sclk  = 1'b1;
    lrclk = 1'b1;
    full  = 1'b0;
    reset_pulse();
    for (int i = 0; i < 4; i++) drive_bit(i != 3, 1'($urandom));
  endtask

  task automatic end_phase();
    commit();
    drive_bit(1'b0, 1'($urandom));
    drive_bit(1'b0, 1'($urandom));
    repeat (10) @(negedge clk);
    check("drained", 64'(exp_q.size()), 64'(0));
    check("overflow_end", 64'(overflow), 64'(ovf_exp));
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int slots[5];
    int sl;
    int pa;
    slots = '{16, 20, 24, 28, 32};

    // Ramp: 64fs, fixed pattern.
    start_phase();
    for (int f = 0; f < 4; f++) send_frame(24'hA5A5A5, 24'h123456, 32, 1'b0, -1, -1);
    end_phase();

    // One-bit delay: MSB right after the lrclk fall, LSB set.
    start_phase();
    for (int f = 0; f < 2; f++) send_frame(24'h800001, 24'($urandom), 32, 1'b0, -1, -1);
    end_phase();

    // Short 16-bit slots.
    start_phase();
    for (int f = 0; f < 3; f++) begin
      send_frame({16'hBEEF, 8'($urandom)}, 24'($urandom), 16, 1'b0, -1, -1);
    end
    end_phase();

    // Overflow: the frame closed while full is dropped, later ones written.
    start_phase();
    send_frame(24'h111111, 24'h222222, 32, 1'b0, -1, -1);
    send_frame(24'h333333, 24'h444444, 32, 1'b1, -1, -1);
    send_frame(24'h555555, 24'h666666, 32, 1'b0, -1, -1);
    send_frame(24'h777777, 24'h888888, 32, 1'b0, -1, -1);
    end_phase();

    // Mid-frame reset during a right slot, with a stopped sclk mid-word after.
    start_phase();
    send_frame(24'hABCDEF, 24'h012345, 32, 1'b0, -1, -1);
    send_frame(24'hDEAD00, 24'h00BEEF, 32, 1'b0, 10, -1);
    send_frame(24'hC0FFEE, 24'hFACADE, 32, 1'b0, -1, 7);
    send_frame(24'h5A5A5A, 24'hA5A5A5, 32, 1'b0, -1, -1);
    end_phase();

    // Random frames: mixed slot widths, junk bits past DW, pauses, full.
    start_phase();
    for (int f = 0; f < 12; f++) begin
      sl = slots[$urandom_range(0, 4)];
      pa = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, sl - 1)) : -1;
      send_frame(24'($urandom), 24'($urandom), sl, $urandom_range(0, 5) == 0, -1, pa);
    end
    end_phase();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
